// File: rtl/rob_commit.sv
// -----------------------------------------------------------------------------
// rob_commit -- reorder buffer with in-order single-instruction commit.
//
// Instructions allocate an entry at the tail in program order, complete out of
// order (EXE writes the result into the entry named by ROBPointer_IN) and
// retire in order from the head, one per cycle. Retiring a taken branch/jump
// flushes the whole buffer and redirects fetch.
//
// Optional feature (macro ROB_PERF_CNT_EN):
//   defined   -> Commit_Count_OUT is a 32-bit retired-instruction counter
//   undefined -> Commit_Count_OUT is tied to 0 and no counter is built
//
// Parameters:
//   ROBWIDTH              entry-index width, depth = 2**ROBWIDTH
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   FREEZE                stall: no allocate/complete/retire, state held
//   Alloc_Valid_IN        allocate an entry for the instruction at Alloc_PC_IN
//   Alloc_ROBPointer_OUT  index granted to the allocating instruction (tail)
//   ROB_Full_OUT          all entries in use
//   ROB_Empty_OUT         no entries in use
//   Valid_Instruction_IN  completion from EXE for entry ROBPointer_IN, with
//                         aluresult_IN / writeRegister1_IN / RegDest_IN /
//                         Branch_flag_IN / target_PC_IN
//   fwd_data_1_COM, fwd_reg_1_COM, fwd_data_1_COM_flag
//                         committed result, destination, writes-register flag
//   Commit_Valid_OUT      one-cycle pulse per retired instruction
//   Commit_PC_OUT         PC of the retired instruction
//   Flush_OUT             one-cycle pulse when a taken branch retires
//   Redirect_PC_OUT       fetch target during the flush pulse, 0 otherwise
//   Commit_Count_OUT      retired-instruction counter (see macro above)
// -----------------------------------------------------------------------------
module rob_commit #(
  parameter int ROBWIDTH = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  // allocation
  input  logic                Alloc_Valid_IN,
  input  logic [31:0]         Alloc_PC_IN,
  output logic [ROBWIDTH-1:0] Alloc_ROBPointer_OUT,
  output logic                ROB_Full_OUT,
  output logic                ROB_Empty_OUT,
  // completion
  input  logic                Valid_Instruction_IN,
  input  logic [ROBWIDTH-1:0] ROBPointer_IN,
  input  logic [31:0]         aluresult_IN,
  input  logic [5:0]          writeRegister1_IN,
  input  logic                RegDest_IN,
  input  logic                Branch_flag_IN,
  input  logic [31:0]         target_PC_IN,
  // commit
  output logic [31:0]         fwd_data_1_COM,
  output logic [5:0]          fwd_reg_1_COM,
  output logic                fwd_data_1_COM_flag,
  output logic                Commit_Valid_OUT,
  output logic [31:0]         Commit_PC_OUT,
  output logic                Flush_OUT,
  output logic [31:0]         Redirect_PC_OUT,
  output logic [31:0]         Commit_Count_OUT
);

  localparam int DEPTH = 1 << ROBWIDTH;
  localparam logic [ROBWIDTH:0] PTR_ONE = {{ROBWIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Entry storage. valid/done are reset; the payload fields are only ever
  // read while the entry is valid and done, so they carry no reset.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [31:0]      ent_pc      [DEPTH];
  logic [31:0]      ent_result  [DEPTH];
  logic [5:0]       ent_dest    [DEPTH];
  logic [DEPTH-1:0] ent_regdest;
  logic [DEPTH-1:0] ent_taken;
  logic [31:0]      ent_target  [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ROBWIDTH:0]   head;
  logic [ROBWIDTH:0]   tail;
  logic [ROBWIDTH-1:0] head_idx;
  logic [ROBWIDTH-1:0] tail_idx;

  logic rob_full;
  logic rob_empty;
  logic do_alloc;
  logic do_complete;
  logic do_retire;
  logic do_flush;

  assign head_idx = head[ROBWIDTH-1:0];
  assign tail_idx = tail[ROBWIDTH-1:0];

  assign rob_full  = (head_idx == tail_idx) && (head[ROBWIDTH] != tail[ROBWIDTH]);
  assign rob_empty = (head == tail);

  assign ROB_Full_OUT         = rob_full;
  assign ROB_Empty_OUT        = rob_empty;
  assign Alloc_ROBPointer_OUT = tail_idx;

  // Allocation is gated on the current full flag only: a retire in the same
  // cycle does not free a slot until the next cycle.
  assign do_alloc    = Alloc_Valid_IN && !rob_full && !FREEZE;
  // Completions aimed at an entry that is not in flight are dropped.
  assign do_complete = Valid_Instruction_IN && ent_valid[ROBPointer_IN] && !FREEZE;
  // done is a registered bit, so a completion can only retire one edge later.
  assign do_retire   = !FREEZE && ent_valid[head_idx] && ent_done[head_idx];
  assign do_flush    = do_retire && ent_taken[head_idx];

  // ---------------------------------------------------------------------------
  // Pointer and valid/done bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (do_flush) begin
      // Everything younger than the branch is wrong-path: drop it all, along
      // with any allocation or completion arriving on this edge.
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      // Order matters only for the head entry: a late completion aimed at the
      // entry being retired must not leave a stale done bit behind.
      if (do_complete) begin
        ent_done[ROBPointer_IN] <= 1'b1;
      end
      if (do_retire) begin
        ent_valid[head_idx] <= 1'b0;
        ent_done[head_idx]  <= 1'b0;
        head                <= head + PTR_ONE;
      end
      // The tail slot is never the retiring head: equal indices mean empty
      // (no retire) or full (no allocation).
      if (do_alloc) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= 1'b0;
        tail                <= tail + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!do_flush) begin
      if (do_alloc) begin
        ent_pc[tail_idx] <= Alloc_PC_IN;
      end
      if (do_complete) begin
        ent_result[ROBPointer_IN]  <= aluresult_IN;
        ent_dest[ROBPointer_IN]    <= writeRegister1_IN;
        ent_regdest[ROBPointer_IN] <= RegDest_IN;
        ent_taken[ROBPointer_IN]   <= Branch_flag_IN;
        ent_target[ROBPointer_IN]  <= target_PC_IN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered commit outputs. Flags pulse for one cycle; data, register and
  // PC keep the last retired values so downstream forwarding stays stable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fwd_data_1_COM      <= '0;
      fwd_reg_1_COM       <= '0;
      fwd_data_1_COM_flag <= 1'b0;
      Commit_Valid_OUT    <= 1'b0;
      Commit_PC_OUT       <= '0;
      Flush_OUT           <= 1'b0;
      Redirect_PC_OUT     <= '0;
    end else begin
      fwd_data_1_COM_flag <= 1'b0;
      Commit_Valid_OUT    <= 1'b0;
      Flush_OUT           <= 1'b0;
      Redirect_PC_OUT     <= '0;
      if (do_retire) begin
        fwd_data_1_COM      <= ent_result[head_idx];
        fwd_reg_1_COM       <= ent_dest[head_idx];
        fwd_data_1_COM_flag <= ent_regdest[head_idx];
        Commit_Valid_OUT    <= 1'b1;
        Commit_PC_OUT       <= ent_pc[head_idx];
      end
      if (do_flush) begin
        Flush_OUT       <= 1'b1;
        Redirect_PC_OUT <= ent_target[head_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      commit_count <= '0;
    end else if (do_retire) begin
      commit_count <= commit_count + 32'd1;
    end
  end

  assign Commit_Count_OUT = commit_count;
`else
  assign Commit_Count_OUT = '0;
`endif

endmodule
